// File: rtl/byte_arb_pkg.sv
// Shared types and the rotating-priority pick for the N-client byte arbiter.
package byte_arb_pkg;

  localparam int DROP_W = 16;
  localparam int MAX_N  = 16;

  typedef enum logic {IDLE, LOCKED} pkt_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req searching ptr+1, ptr+2, ... modulo n.
  // Walks the distances backwards so the nearest candidate is written last.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                       input logic [3:0] ptr, input int n);
    rr_pick_t p;
    int j;
    p = '0;
    for (int k = MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (req[j[3:0]]) begin
          p.valid = 1'b1;
          p.idx   = j[3:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/byte_arbiter_rr_rr_arbiter.sv
// Combinational round-robin selector; optional mask restricts eligibility to one index.
module rr_arbiter
  import byte_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mask_en,
  input  logic [IW-1:0] mask_idx,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [MAX_N-1:0] elig;
  rr_pick_t         pick;

  always_comb begin
    elig        = '0;
    elig[N-1:0] = req;
    if (mask_en) elig = elig & (MAX_N'(1) << mask_idx);
    pick        = rr_pick(elig, 4'(ptr), N);
    gnt_valid   = pick.valid;
    gnt_idx     = IW'(pick.idx);
    gnt_onehot  = pick.valid ? (N'(1) << pick.idx) : '0;
  end

endmodule

// File: rtl/byte_arbiter_rr.sv
// N-client byte arbiter: round-robin tx onto one serdes port, ID-routed rx back to clients.
module byte_arbiter_rr
  import byte_arb_pkg::*;
#(
  parameter int N_CLIENTS   = 4,
  parameter int DATA_W      = 8,
  parameter int ID_W        = $clog2(N_CLIENTS),
  parameter int PACKET_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CLIENTS-1:0]        c_tx_req,
  input  logic [N_CLIENTS*DATA_W-1:0] c_tx_data,
  input  logic [N_CLIENTS-1:0]        c_tx_last,
  output logic [N_CLIENTS-1:0]        c_tx_acc,
  output logic [N_CLIENTS-1:0]        c_rx_req,
  output logic [DATA_W-1:0]           c_rx_data,
  input  logic [N_CLIENTS-1:0]        c_rx_acc,
  output logic                        s_tx_req,
  output logic [DATA_W-1:0]           s_tx_data,
  output logic [ID_W-1:0]             s_tx_id,
  input  logic                        s_tx_gnt,
  input  logic                        s_rx_req,
  input  logic [DATA_W-1:0]           s_rx_data,
  input  logic [ID_W-1:0]             s_rx_id,
  output logic                        s_rx_gnt,
  output logic [DROP_W-1:0]           drop_cnt
);

  pkt_state_t           state;
  logic [ID_W-1:0]      rr_ptr, owner, gnt_idx, ireg_id;
  logic [N_CLIENTS-1:0] gnt_onehot;
  logic [DATA_W-1:0]    win_data, ireg_data;
  logic                 free, lock_en, gnt_valid, tx_fire, win_last;
  logic                 ireg_valid, rx_drain, rx_fire, id_ok;

  // ---------------- tx ----------------
  assign free    = !s_tx_req || s_tx_gnt;
  assign lock_en = (PACKET_MODE != 0) && (state == LOCKED);

  rr_arbiter #(.N(N_CLIENTS), .IW(ID_W)) u_arb (
    .req        (c_tx_req),
    .ptr        (rr_ptr),
    .mask_en    (lock_en),
    .mask_idx   (owner),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  assign tx_fire  = !rst && free && gnt_valid;
  assign c_tx_acc = tx_fire ? gnt_onehot : '0;
  assign win_last = |(gnt_onehot & c_tx_last);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      if (gnt_onehot[i]) win_data = win_data | c_tx_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_tx_req  <= 1'b0;
      s_tx_data <= '0;
      s_tx_id   <= '0;
      rr_ptr    <= ID_W'(N_CLIENTS - 1);
    end else if (tx_fire) begin
      s_tx_req  <= 1'b1;
      s_tx_data <= win_data;
      s_tx_id   <= gnt_idx;
      rr_ptr    <= gnt_idx;
    end else if (s_tx_gnt) begin
      s_tx_req  <= 1'b0;
    end
  end

  // Packet lock: a single-word packet (last on first word) never locks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
    end else if (PACKET_MODE != 0 && tx_fire) begin
      case (state)
        IDLE:    if (!win_last) begin
                   state <= LOCKED;
                   owner <= gnt_idx;
                 end
        LOCKED:  if (win_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- rx ----------------
  assign c_rx_req  = ireg_valid ? (N_CLIENTS'(1) << ireg_id) : '0;
  assign c_rx_data = ireg_data;
  assign rx_drain  = |(c_rx_req & c_rx_acc);
  assign s_rx_gnt  = !rst && (!ireg_valid || rx_drain);
  assign rx_fire   = s_rx_req && s_rx_gnt;
  assign id_ok     = 32'(s_rx_id) < N_CLIENTS;

  always_ff @(posedge clk) begin
    if (rst) begin
      ireg_valid <= 1'b0;
      ireg_id    <= '0;
      ireg_data  <= '0;
      drop_cnt   <= '0;
    end else begin
      if (rx_fire && id_ok) begin
        ireg_valid <= 1'b1;
        ireg_id    <= s_rx_id;
        ireg_data  <= s_rx_data;
      end else if (rx_drain) begin
        ireg_valid <= 1'b0;
      end
      if (rx_fire && !id_ok && drop_cnt != {DROP_W{1'b1}})
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_arbiter_rr.sv
// Bench for byte_arbiter_rr: directed scenarios plus randomized traffic vs a cycle model.
module tb_byte_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  c_tx_req, c_tx_last, c_rx_acc;
  logic [31:0] c_tx_data;
  logic        s_tx_gnt, s_rx_req;
  logic [7:0]  s_rx_data;
  logic [2:0]  s_rx_id;

  logic [3:0]  acc0, rxreq0, acc1, rxreq1;
  logic [7:0]  rxdata0, txdata0, rxdata1, txdata1;
  logic        txreq0, rxgnt0, txreq1, rxgnt1;
  logic [2:0]  txid0;
  logic [1:0]  txid1;
  logic [15:0] drop0, drop1;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  byte_arbiter_rr #(.N_CLIENTS(4), .DATA_W(8), .ID_W(3), .PACKET_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .c_tx_req(c_tx_req), .c_tx_data(c_tx_data), .c_tx_last(c_tx_last),
    .c_tx_acc(acc0), .c_rx_req(rxreq0), .c_rx_data(rxdata0), .c_rx_acc(c_rx_acc),
    .s_tx_req(txreq0), .s_tx_data(txdata0), .s_tx_id(txid0), .s_tx_gnt(s_tx_gnt),
    .s_rx_req(s_rx_req), .s_rx_data(s_rx_data), .s_rx_id(s_rx_id), .s_rx_gnt(rxgnt0),
    .drop_cnt(drop0));

  byte_arbiter_rr #(.N_CLIENTS(4), .DATA_W(8), .PACKET_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .c_tx_req(c_tx_req), .c_tx_data(c_tx_data), .c_tx_last(c_tx_last),
    .c_tx_acc(acc1), .c_rx_req(rxreq1), .c_rx_data(rxdata1), .c_rx_acc(4'b0000),
    .s_tx_req(txreq1), .s_tx_data(txdata1), .s_tx_id(txid1), .s_tx_gnt(s_tx_gnt),
    .s_rx_req(1'b0), .s_rx_data(8'h00), .s_rx_id(2'b00), .s_rx_gnt(rxgnt1),
    .drop_cnt(drop1));

  // ---------------- reference model (index 0: plain RR, index 1: packet mode) ----------------
  int         m_ptr[2] = '{3, 3};
  int         m_oid[2] = '{0, 0};
  bit         m_ov[2]  = '{0, 0};
  logic [7:0] m_od[2]  = '{8'h00, 8'h00};
  bit         m_lock = 0;
  int         m_own = 0;
  bit         m_iv = 0;
  int         m_iid = 0;
  logic [7:0] m_idata = 8'h00;
  int         m_drop = 0;

  function automatic int m_win(int m);
    int i;
    if (rst || (m_ov[m] && !s_tx_gnt)) return -1;
    for (int k = 1; k <= 4; k++) begin
      i = (m_ptr[m] + k) % 4;
      if (c_tx_req[i] && !(m == 1 && m_lock && i != m_own)) return i;
    end
    return -1;
  endfunction

  function automatic bit m_rxg();
    return !rst && (!m_iv || c_rx_acc[m_iid]);
  endfunction

  initial forever begin
    int w;
    bit g;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      w = m_win(m);
      if (rst) begin
        m_ov[m] = 0; m_od[m] = 8'h00; m_oid[m] = 0; m_ptr[m] = 3;
        if (m == 1) m_lock = 0;
      end else begin
        if (m_ov[m] && s_tx_gnt) m_ov[m] = 0;
        if (w >= 0) begin
          m_ov[m] = 1; m_od[m] = c_tx_data[w*8 +: 8]; m_oid[m] = w; m_ptr[m] = w;
          if (m == 1 && !m_lock && !c_tx_last[w]) begin m_lock = 1; m_own = w; end
          else if (m == 1 && m_lock && c_tx_last[w]) m_lock = 0;
        end
      end
    end
    g = m_rxg();
    if (rst) begin
      m_iv = 0; m_idata = 8'h00; m_drop = 0;
    end else begin
      if (m_iv && c_rx_acc[m_iid]) m_iv = 0;
      if (s_rx_req && g) begin
        if (s_rx_id < 4) begin m_iv = 1; m_iid = int'(s_rx_id); m_idata = s_rx_data; end
        else if (m_drop < 65535) m_drop++;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1; c_tx_req = 0; c_tx_data = 0; c_tx_last = 4'hF; c_rx_acc = 0;
    s_tx_gnt = 0; s_rx_req = 0; s_rx_data = 0; s_rx_id = 0;
    repeat (2) @(negedge clk);
    c_tx_req = 4'hF; s_rx_req = 1; #1;
    n_chk++;
    if ({acc0, acc1, rxgnt0, rxgnt1} !== 10'h0) begin
      n_fail++; $display("FAIL reset_handshake: acc0=%b acc1=%b rxgnt0=%b rxgnt1=%b want all 0", acc0, acc1, rxgnt0, rxgnt1);
    end
    n_chk++;
    if ({txreq0, txdata0, txid0, rxreq0, rxdata0, drop0, txreq1, rxreq1, drop1} !== 61'h0) begin
      n_fail++; $display("FAIL reset_regs: txreq=%b txdata=%h txid=%0d rxreq=%b rxdata=%h drop=%0d want 0", txreq0, txdata0, txid0, rxreq0, rxdata0, drop0);
    end
    s_rx_req = 0;
  endtask

  task automatic test_rr;
    logic [3:0] e;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst = 0; c_tx_req = 4'hF; c_tx_data = 32'h13121110; s_tx_gnt = 1; #1;
      e = 4'b0001 << (k % 4);
      n_chk++;
      if (acc0 !== e || acc1 !== e) begin
        n_fail++; $display("FAIL rr_acc[%0d]: acc0=%b acc1=%b want %b", k, acc0, acc1, e);
      end
      if (k > 0) begin
        n_chk++;
        if ({txreq0, txdata0, txid0} !== {1'b1, 8'(16 + (k-1) % 4), 3'((k-1) % 4)}) begin
          n_fail++; $display("FAIL rr_word[%0d]: req=%b data=%h id=%0d want id %0d", k, txreq0, txdata0, txid0, (k-1) % 4);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk); c_tx_req = 0;
    @(negedge clk); s_tx_gnt = 0; c_tx_req = 4'b0100; c_tx_data = 32'h3CA51110; #1;
    n_chk++;
    if (acc0 !== 4'b0100 || txreq0 !== 1'b0) begin
      n_fail++; $display("FAIL bp_first: acc=%b txreq=%b want 0100/0", acc0, txreq0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); c_tx_req = 4'b1000; #1;
      n_chk++;
      if ({acc0, txreq0, txdata0, txid0} !== {4'b0000, 1'b1, 8'hA5, 3'd2}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: acc=%b req=%b data=%h id=%0d want 0000/1/a5/2", k, acc0, txreq0, txdata0, txid0);
      end
    end
    @(negedge clk); s_tx_gnt = 1; #1;
    n_chk++;
    if (acc0 !== 4'b1000 || txdata0 !== 8'hA5) begin
      n_fail++; $display("FAIL bp_release: acc=%b data=%h want 1000/a5", acc0, txdata0);
    end
    @(negedge clk); c_tx_req = 0; #1;
    n_chk++;
    if ({txreq0, txdata0, txid0} !== {1'b1, 8'h3C, 3'd3}) begin
      n_fail++; $display("FAIL bp_next: req=%b data=%h id=%0d want 1/3c/3", txreq0, txdata0, txid0);
    end
    @(negedge clk); #1;
    n_chk++;
    if (txreq0 !== 1'b0) begin
      n_fail++; $display("FAIL bp_single: txreq=%b want 0", txreq0);
    end
  endtask

  task automatic test_packet;
    logic [3:0]  rq[7] = '{4'b1010, 4'b1000, 4'b1000, 4'b1010, 4'b1010, 4'b1000, 4'b0000};
    logic [7:0]  dd[7] = '{8'h71, 8'h71, 8'h71, 8'h72, 8'h73, 8'h73, 8'h73};
    logic        ls[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  ea[7] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b0000};
    logic [10:0] et[7] = '{{1'b0, 8'h00, 2'd0}, {1'b1, 8'h71, 2'd1}, {1'b0, 8'h71, 2'd1},
                           {1'b0, 8'h71, 2'd1}, {1'b1, 8'h72, 2'd1}, {1'b1, 8'h73, 2'd1},
                           {1'b1, 8'hC3, 2'd3}};
    @(negedge clk); rst = 1; c_tx_req = 0;
    for (int p = 0; p < 7; p++) begin
      @(negedge clk);
      rst = 0; c_tx_req = rq[p]; c_tx_data = {8'hC3, 8'h00, dd[p], 8'h00};
      c_tx_last = {1'b1, 1'b0, ls[p], 1'b0}; #1;
      n_chk++;
      if (acc1 !== ea[p] || {txreq1, txdata1, txid1} !== et[p]) begin
        n_fail++; $display("FAIL pkt[%0d]: acc=%b tx=%h want acc=%b tx=%h", p, acc1, {txreq1, txdata1, txid1}, ea[p], et[p]);
      end
      if (p == 1) begin
        n_chk++;
        if (acc0 !== 4'b1000) begin
          n_fail++; $display("FAIL pkt_nolock_mode0: acc0=%b want 1000", acc0);
        end
      end
    end
    c_tx_last = 4'hF;
  endtask

  task automatic test_rx;
    @(negedge clk); c_rx_acc = 4'hF; s_rx_req = 1; s_rx_id = 3'd2; s_rx_data = 8'h55; #1;
    n_chk++;
    if (rxgnt0 !== 1'b1) begin n_fail++; $display("FAIL rx_gnt0: gnt=%b want 1", rxgnt0); end
    @(negedge clk); s_rx_id = 3'd0; s_rx_data = 8'h66; #1;
    n_chk++;
    if ({rxreq0, rxdata0, rxgnt0} !== {4'b0100, 8'h55, 1'b1}) begin
      n_fail++; $display("FAIL rx_word0: req=%b data=%h gnt=%b want 0100/55/1", rxreq0, rxdata0, rxgnt0);
    end
    @(negedge clk); s_rx_req = 0; #1;
    n_chk++;
    if ({rxreq0, rxdata0, rxgnt0} !== {4'b0001, 8'h66, 1'b1}) begin
      n_fail++; $display("FAIL rx_word1: req=%b data=%h gnt=%b want 0001/66/1", rxreq0, rxdata0, rxgnt0);
    end
    @(negedge clk); #1;
    n_chk++;
    if (rxreq0 !== 4'b0000) begin n_fail++; $display("FAIL rx_empty: req=%b want 0000", rxreq0); end
  endtask

  task automatic test_rx_stall_drop;
    @(negedge clk); c_rx_acc = 4'b1101; s_rx_req = 1; s_rx_id = 3'd1; s_rx_data = 8'h77; #1;
    n_chk++;
    if (rxgnt0 !== 1'b1) begin n_fail++; $display("FAIL stall_gnt: gnt=%b want 1", rxgnt0); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); s_rx_id = 3'd5; s_rx_data = 8'h99; #1;
      n_chk++;
      if ({rxreq0, rxdata0, rxgnt0} !== {4'b0010, 8'h77, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: req=%b data=%h gnt=%b want 0010/77/0", k, rxreq0, rxdata0, rxgnt0);
      end
    end
    @(negedge clk); c_rx_acc = 4'hF; #1;
    n_chk++;
    if (rxgnt0 !== 1'b1) begin n_fail++; $display("FAIL stall_release: gnt=%b want 1", rxgnt0); end
    @(negedge clk); s_rx_req = 0; #1;
    n_chk++;
    if ({rxreq0, drop0} !== {4'b0000, 16'd1}) begin
      n_fail++; $display("FAIL drop: rxreq=%b drop=%0d want 0000/1", rxreq0, drop0);
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk); s_tx_gnt = 0; c_tx_req = 4'b0001; c_tx_data = 32'h000000E1;
    s_rx_req = 1; s_rx_id = 3'd3; s_rx_data = 8'h33; c_rx_acc = 0; #1;
    @(negedge clk); c_tx_req = 0; s_rx_req = 0; #1;
    n_chk++;
    if ({txreq0, txdata0, rxreq0, rxdata0} !== {1'b1, 8'hE1, 4'b1000, 8'h33}) begin
      n_fail++; $display("FAIL mid_full: txreq=%b txdata=%h rxreq=%b rxdata=%h", txreq0, txdata0, rxreq0, rxdata0);
    end
    @(negedge clk); rst = 1; c_tx_req = 4'hF; s_rx_req = 1; s_rx_id = 3'd1; #1;
    n_chk++;
    if ({acc0, rxgnt0} !== 5'h0) begin
      n_fail++; $display("FAIL mid_rst_hs: acc=%b gnt=%b want 0", acc0, rxgnt0);
    end
    @(negedge clk); rst = 0; s_tx_gnt = 1; s_rx_req = 0; c_tx_data = 32'h13121110; #1;
    n_chk++;
    if ({txreq0, rxreq0, drop0, acc0, acc1} !== {1'b0, 4'b0000, 16'd0, 4'b0001, 4'b0001}) begin
      n_fail++; $display("FAIL mid_after: txreq=%b rxreq=%b drop=%0d acc0=%b acc1=%b", txreq0, rxreq0, drop0, acc0, acc1);
    end
  endtask

  task automatic test_random;
    int pw, w0, w1;
    bit pg;
    logic [44:0] a0, e0;
    logic [19:0] a1, e1;
    pw = -1; pg = 1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++)
        if (!c_tx_req[i] || pw == i) begin
          c_tx_req[i] = ($urandom_range(0, 2) != 0);
          c_tx_data[i*8 +: 8] = 8'($urandom);
          c_tx_last[i] = ($urandom_range(0, 2) == 0);
        end
      s_tx_gnt = ($urandom_range(0, 3) != 0);
      c_rx_acc = 4'($urandom);
      if (!s_rx_req || pg) begin
        s_rx_req = 1'($urandom_range(0, 1)); s_rx_id = 3'($urandom); s_rx_data = 8'($urandom);
      end
      #1;
      w0 = m_win(0); w1 = m_win(1);
      e0 = {(w0 >= 0) ? 4'(1 << w0) : 4'h0, m_ov[0], m_od[0], 3'(m_oid[0]),
            m_iv ? 4'(1 << m_iid) : 4'h0, m_idata, m_rxg(), 16'(m_drop)};
      a0 = {acc0, txreq0, txdata0, txid0, rxreq0, rxdata0, rxgnt0, drop0};
      e1 = {(w1 >= 0) ? 4'(1 << w1) : 4'h0, m_ov[1], m_od[1], 2'(m_oid[1]), 4'h0, !rst};
      a1 = {acc1, txreq1, txdata1, txid1, rxreq1, rxgnt1};
      n_chk++;
      if (a0 !== e0) begin n_fail++; $display("FAIL rand_mode0[%0d]: got %h want %h", t, a0, e0); end
      n_chk++;
      if (a1 !== e1) begin n_fail++; $display("FAIL rand_mode1[%0d]: got %h want %h", t, a1, e1); end
      pw = w0;
      pg = m_rxg() && s_rx_req;
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_backpressure();
    test_packet();
    test_rx();
    test_rx_stall_drop();
    test_reset_midflight();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_arbiter_rr.md
Name: byte_arbiter_rr

Overview:
- Parametrised N-client arbiter between client byte ports and one serdes parallel port. Next generation of the single-client byte arbiter.
- Tx: round-robin arbitration across clients. The winner's word is forwarded with its client ID.
- Rx: words are routed back to the client addressed by the serdes-side ID.
- Optional packet mode holds the grant on one client until it marks the last word.

Parameters:
- N_CLIENTS, 4, number of client ports (2..16)
- DATA_W, 8, word width
- ID_W, $clog2(N_CLIENTS), width of client ID field
- PACKET_MODE, 0, 1 = grant held until the client asserts tx_last on an accepted word

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- c_tx_req  in  N_CLIENTS  per-client tx request
- c_tx_data  in  N_CLIENTS*DATA_W  per-client tx word; client i occupies bits [i*DATA_W +: DATA_W]
- c_tx_last  in  N_CLIENTS  per-client end-of-packet marker (used only when PACKET_MODE=1)
- c_tx_acc  out  N_CLIENTS  per-client tx accept, one-hot or zero
- c_rx_req  out  N_CLIENTS  per-client rx request, one-hot or zero
- c_rx_data  out  DATA_W  rx word, shared by all clients
- c_rx_acc  in  N_CLIENTS  per-client rx accept
- s_tx_req  out  1  serdes tx request
- s_tx_data  out  DATA_W  serdes tx word
- s_tx_id  out  ID_W  originating client of s_tx_data
- s_tx_gnt  in  1  serdes tx grant
- s_rx_req  in  1  serdes rx request
- s_rx_data  in  DATA_W  serdes rx word
- s_rx_id  in  ID_W  destination client
- s_rx_gnt  out  1  serdes rx grant
- drop_cnt  out  16  saturating count of rx words with ID >= N_CLIENTS

Behaviour:
- Handshake, all ports: a transfer occurs in a cycle where req and acc/gnt are both 1. The source holds req and data stable until that transfer.
- Reset values: c_tx_acc=0, c_rx_req=0, s_tx_req=0, s_rx_gnt=0, s_tx_data=0, s_tx_id=0, c_rx_data=0, drop_cnt=0, rr_ptr=N_CLIENTS-1, lock=0.
- Reset mid-transfer discards held words. No handshake completes in the reset cycle.

Tx output register (OREG: s_tx_req/data/id):
- OREG may load when `free` = !s_tx_req || s_tx_gnt.

Tx arbitration (combinational, same cycle):
- When free and any c_tx_req is set, grant the first requesting index searching rr_ptr+1, rr_ptr+2, ... modulo N_CLIENTS.
- Assert c_tx_acc[winner] and load OREG with that client's data and ID.
- Set rr_ptr = winner.
- Latency: the word appears on s_tx_* the cycle after c_tx_acc.
- Throughput: one word per cycle while s_tx_gnt is held high.
- When !free, c_tx_acc = 0.

Packet mode (PACKET_MODE=1):
- FSM states: IDLE and LOCKED(owner).
- IDLE -> LOCKED on an accept where c_tx_last[winner]=0.
- While LOCKED, only the owner is eligible. Other requests wait even if the owner's req is low.
- LOCKED -> IDLE on an owner accept with c_tx_last=1.
- A single-word packet (last=1 on the first word) never enters LOCKED.
- rr_ptr updates on every accept.

PACKET_MODE=0: c_tx_last is ignored.

Rx holding register (IREG):
- s_rx_gnt = !ireg_valid || (c_rx_req[ireg_id] && c_rx_acc[ireg_id]).
- On s_rx_req && s_rx_gnt:
  - If s_rx_id < N_CLIENTS, load IREG.
  - Otherwise accept the word, drop it, and increment drop_cnt, saturating at 0xFFFF. IREG is not loaded, so ireg_valid clears if IREG drained in the same cycle.
- c_rx_req[ireg_id] = ireg_valid. All other c_rx_req bits are 0. c_rx_data = ireg_data.
- Rx latency: 1 cycle.
- Back-to-back rx with no bubble when the destination accepts every cycle.
- Simultaneous tx and rx activity is fully independent.

Decomposition:
- Package byte_arb_pkg: holds the drop-counter width constant (16), the typedef for the packet FSM states (IDLE, LOCKED), and the function rr_pick(req, ptr) that returns the winner index and a valid flag.
- One sub-module, rr_arbiter: parameter N, inputs req, ptr, mask_en, mask_idx; outputs gnt_onehot, gnt_idx, gnt_valid. Purely combinational. All state (rr_ptr, lock/owner) stays in the top level.

Test Plan:
- Reset, N=4, PACKET_MODE=0, clients 0..3 request constantly with data 0x10+i, s_tx_gnt=1:
  - s_tx_id sequence is 0,1,2,3,0,...
  - One word per cycle, starting the cycle after the first c_tx_acc.
- Backpressure: s_tx_gnt=0 for 5 cycles with client 2 requesting (0xA5):
  - s_tx_req=1 holds 0xA5 stable.
  - c_tx_acc stays 0 after the first accept.
  - When gnt rises, a single transfer occurs.
- PACKET_MODE=1: client 1 sends 3 words with last on the third while client 3 requests throughout:
  - s_tx_id = 1,1,1 then 3.
  - Client 3 is not accepted during the packet, even with client 1's req dropped for 2 cycles mid-packet.
- Rx routing: s_rx words (id=2, 0x55), (id=0, 0x66) back-to-back, with clients accepting immediately:
  - c_rx_req[2] with 0x55, then c_rx_req[0] with 0x66.
  - s_rx_gnt stays 1 throughout.
- Rx stall and drop: client 1 holds c_rx_acc=0 for 4 cycles:
  - s_rx_gnt=0 while the word is held.
  - Afterwards, an id=5 word (N=4) is accepted, drop_cnt=1, and no c_rx_req fires.
- Reset asserted while OREG and IREG are full:
  - The next cycle, s_tx_req=0, c_rx_req=0 and drop_cnt=0.
  - The arbiter restarts from client 0.
